ahb_ram_arbiter: RTL and testbench

Two-master AHB-Lite slave that shares one single-ported synchronous RAM bank between the RISC-V core's instruction-fetch bus (imem) and data bus (dmem). It captures each master's address phase, serialises RAM accesses one per cycle, and stretches the losing master's data phase with hready when both contend. A per-bank favour bit enforces round-robin fairness. One instance sits between the core buses and each RAM bank, replacing the fixed combinational routing path for that bank.

---
 rtl/ahb_ram_arbiter_if.sv | 22 ++
 rtl/ahb_ram_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_ram_arbiter_if.sv
// AHB-Lite master bus bundle used between one core bus (imem or dmem) and the RAM arbiter.
// The master modport drives the address/data phase; the slave modport returns data and status.
interface ahb_ram_arbiter_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-Lite slave sharing one single-ported synchronous RAM bank with round-robin arbitration.
// Optional address/alignment error responses are compiled in with `define MEM_ARB_ERR_EN.
module ahb_ram_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  ahb_ram_arbiter_if.slave     imem,
  ahb_ram_arbiter_if.slave     dmem,
  output logic                 ram_en,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_rwn,
  output logic [3:0]           ram_wben,
  output logic [31:0]          ram_write,
  input  logic [31:0]          ram_read
);

`ifdef MEM_ARB_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

  // Index 0 is imem, index 1 is dmem throughout.
  logic [31:0]       haddr  [2];
  logic [1:0]        htrans [2];
  logic              hwrite [2];
  logic [2:0]        hsize  [2];
  logic [31:0]       hwdata [2];
  logic [31:0]       hrdata [2];

  state_t            state_q  [2];
  logic              hready_q [2];
  logic [ADDR_W-1:0] pend_addr  [2];
  logic              pend_write [2];
  logic [2:0]        pend_size  [2];

  logic              favour_q;
  logic [1:0]        wait_v;
  logic [1:0]        gnt;
  logic              gnt_sel;
  logic              cap [2];

  assign haddr[0]  = imem.haddr;
  assign haddr[1]  = dmem.haddr;
  assign htrans[0] = imem.htrans;
  assign htrans[1] = dmem.htrans;
  assign hwrite[0] = imem.hwrite;
  assign hwrite[1] = dmem.hwrite;
  assign hsize[0]  = imem.hsize;
  assign hsize[1]  = dmem.hsize;
  assign hwdata[0] = imem.hwdata;
  assign hwdata[1] = dmem.hwdata;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

`ifdef MEM_ARB_ERR_EN
  logic hresp_q [2];
  logic cap_err [2];

  function automatic logic addr_err(input logic [31:0] a, input logic [2:0] size);
    logic err;
    err = (a[31:ADDR_W] != '0);
    case (size)
      3'b000:  err = err;
      3'b001:  err = err | a[0];
      default: err = err | (a[1:0] != 2'b00);
    endcase
    return err;
  endfunction

  assign cap_err[0] = addr_err(haddr[0], hsize[0]);
  assign cap_err[1] = addr_err(haddr[1], hsize[1]);
  assign imem.hresp = hresp_q[0];
  assign dmem.hresp = hresp_q[1];

  logic unused_htrans_lo;
  assign unused_htrans_lo = ^{htrans[0][0], htrans[1][0]};
`else
  assign imem.hresp = 1'b0;
  assign dmem.hresp = 1'b0;

  // Upper address bits alias onto the bank when error checking is compiled out.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{haddr[0][31:ADDR_W], haddr[1][31:ADDR_W],
                            htrans[0][0], htrans[1][0]};
`endif

  // An address phase is accepted whenever the slave is currently showing hready.
  assign cap[0] = hready_q[0] & htrans[0][1];
  assign cap[1] = hready_q[1] & htrans[1][1];

  assign wait_v = {state_q[1] == S_WAIT, state_q[0] == S_WAIT};

  always_comb begin
    gnt     = 2'b00;
    gnt_sel = 1'b0;
    if (&wait_v) begin
      gnt_sel      = favour_q;
      gnt[favour_q] = 1'b1;
    end else if (wait_v[0]) begin
      gnt_sel = 1'b0;
      gnt[0]  = 1'b1;
    end else if (wait_v[1]) begin
      gnt_sel = 1'b1;
      gnt[1]  = 1'b1;
    end
  end

  // Per-master FSMs and the fairness bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favour_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= S_IDLE;
        hready_q[i] <= 1'b1;
`ifdef MEM_ARB_ERR_EN
        hresp_q[i]  <= 1'b0;
`endif
      end
    end else begin
      if (&wait_v)
        favour_q <= ~favour_q;
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          S_WAIT: begin
            if (gnt[i]) begin
              state_q[i]  <= S_DONE;
              hready_q[i] <= 1'b1;
            end
          end
`ifdef MEM_ARB_ERR_EN
          S_ERR1: begin
            state_q[i]  <= S_ERR2;
            hready_q[i] <= 1'b1;
            hresp_q[i]  <= 1'b1;
          end
`endif
          default: begin
            if (cap[i]) begin
`ifdef MEM_ARB_ERR_EN
              if (cap_err[i]) begin
                state_q[i]  <= S_ERR1;
                hready_q[i] <= 1'b0;
                hresp_q[i]  <= 1'b1;
              end else
`endif
              begin
                state_q[i]  <= S_WAIT;
                hready_q[i] <= 1'b0;
`ifdef MEM_ARB_ERR_EN
                hresp_q[i]  <= 1'b0;
`endif
              end
            end else begin
              state_q[i]  <= S_IDLE;
              hready_q[i] <= 1'b1;
`ifdef MEM_ARB_ERR_EN
              hresp_q[i]  <= 1'b0;
`endif
            end
          end
        endcase
      end
    end
  end

  // Pending address-phase capture; state alone decides whether it is used.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        pend_addr[i]  <= haddr[i][ADDR_W-1:0];
        pend_write[i] <= hwrite[i];
        pend_size[i]  <= hsize[i];
      end
    end
  end

  // RAM side: combinational from the grant so a write lands in the grant cycle.
  always_comb begin
    ram_en    = (|gnt) & ~reset;
    ram_addr  = '0;
    ram_rwn   = 1'b1;
    ram_wben  = 4'b0000;
    ram_write = 32'h0;
    if (ram_en) begin
      ram_addr  = {pend_addr[gnt_sel][ADDR_W-1:2], 2'b00};
      ram_rwn   = ~pend_write[gnt_sel];
      ram_write = hwdata[gnt_sel];
      if (pend_write[gnt_sel])
        ram_wben = lane_mask(pend_size[gnt_sel], pend_addr[gnt_sel][1:0]);
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hrdata[i] = 32'h0;
      if (state_q[i] == S_DONE && !pend_write[i])
        hrdata[i] = ram_read;
    end
  end

  assign imem.hrdata = hrdata[0];
  assign dmem.hrdata = hrdata[1];
  assign imem.hready = hready_q[0];
  assign dmem.hready = hready_q[1];

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed bench for ahb_ram_arbiter: single transfers, lane decode, round-robin, reset abort, error path.
module tb_ahb_ram_arbiter;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rwn;
  logic [3:0]        ram_wben;
  logic [31:0]       ram_write;
  logic [31:0]       ram_read;

  int checks = 0;
  int failures = 0;

  ahb_ram_arbiter_if imem_bus ();
  ahb_ram_arbiter_if dmem_bus ();

  ahb_ram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (imem_bus),
    .dmem      (dmem_bus),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rwn   (ram_rwn),
    .ram_wben  (ram_wben),
    .ram_write (ram_write),
    .ram_read  (ram_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One contested round: both read in the same cycle; win is 0 for imem, 1 for dmem.
  task automatic do_round(input int win);
    logic [1:0]  hr;
    logic [31:0] waddr, laddr;
    waddr = (win == 0) ? 32'h40 : 32'h80;
    laddr = (win == 0) ? 32'h80 : 32'h40;
    cyc();
    imem_bus.haddr = 32'h40; imem_bus.htrans = 2'b10; imem_bus.hwrite = 1'b0; imem_bus.hsize = 3'b010;
    dmem_bus.haddr = 32'h80; dmem_bus.htrans = 2'b10; dmem_bus.hwrite = 1'b0; dmem_bus.hsize = 3'b010;
    @(negedge clk);
    chk("rr_cap_ihready", 32'(imem_bus.hready), 32'h1);
    chk("rr_cap_dhready", 32'(dmem_bus.hready), 32'h1);
    cyc();
    imem_bus.htrans = 2'b00; dmem_bus.htrans = 2'b00;
    @(negedge clk);
    chk("rr_g1_en", 32'(ram_en), 32'h1);
    chk("rr_g1_addr", 32'(ram_addr), waddr);
    chk("rr_g1_ihready", 32'(imem_bus.hready), 32'h0);
    chk("rr_g1_dhready", 32'(dmem_bus.hready), 32'h0);
    cyc();
    @(negedge clk);
    hr = {dmem_bus.hready, imem_bus.hready};
    chk("rr_g2_en", 32'(ram_en), 32'h1);
    chk("rr_g2_addr", 32'(ram_addr), laddr);
    chk("rr_win_hready", 32'(hr[win]), 32'h1);
    chk("rr_lose_hready0", 32'(hr[1-win]), 32'h0);
    chk("rr_win_hrdata", (win == 0) ? imem_bus.hrdata : dmem_bus.hrdata, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    hr = {dmem_bus.hready, imem_bus.hready};
    chk("rr_lose_hready1", 32'(hr[1-win]), 32'h1);
    chk("rr_lose_hrdata", (win == 0) ? dmem_bus.hrdata : imem_bus.hrdata, 32'hDEADBEEF);
    chk("rr_end_en", 32'(ram_en), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_bus.haddr = '0; imem_bus.htrans = 2'b00; imem_bus.hwrite = 1'b0;
    imem_bus.hsize = 3'b010; imem_bus.hwdata = '0;
    dmem_bus.haddr = '0; dmem_bus.htrans = 2'b00; dmem_bus.hwrite = 1'b0;
    dmem_bus.hsize = 3'b010; dmem_bus.hwdata = '0;
    ram_read = 32'hDEADBEEF;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ihready", 32'(imem_bus.hready), 32'h1);
    chk("rst_dhready", 32'(dmem_bus.hready), 32'h1);
    chk("rst_ihresp", 32'(imem_bus.hresp), 32'h0);
    chk("rst_dhresp", 32'(dmem_bus.hresp), 32'h0);
    chk("rst_ihrdata", imem_bus.hrdata, 32'h0);
    chk("rst_dhrdata", dmem_bus.hrdata, 32'h0);
    chk("rst_en", 32'(ram_en), 32'h0);
    chk("rst_wben", 32'(ram_wben), 32'h0);
    chk("rst_rwn", 32'(ram_rwn), 32'h1);

    // imem word read of 0x10
    cyc();
    reset = 1'b0;
    imem_bus.haddr = 32'h10; imem_bus.htrans = 2'b10; imem_bus.hwrite = 1'b0; imem_bus.hsize = 3'b010;
    @(negedge clk);
    chk("rd_a_en", 32'(ram_en), 32'h0);
    cyc();
    imem_bus.htrans = 2'b00;
    @(negedge clk);
    chk("rd_a1_en", 32'(ram_en), 32'h1);
    chk("rd_a1_addr", 32'(ram_addr), 32'h10);
    chk("rd_a1_rwn", 32'(ram_rwn), 32'h1);
    chk("rd_a1_wben", 32'(ram_wben), 32'h0);
    chk("rd_a1_hready", 32'(imem_bus.hready), 32'h0);
    cyc();
    @(negedge clk);
    chk("rd_a2_hready", 32'(imem_bus.hready), 32'h1);
    chk("rd_a2_hrdata", imem_bus.hrdata, 32'hDEADBEEF);
    chk("rd_a2_en", 32'(ram_en), 32'h0);

    // dmem byte write to 0x23, then half write to 0x22 captured in DONE
    cyc();
    dmem_bus.haddr = 32'h23; dmem_bus.htrans = 2'b10; dmem_bus.hwrite = 1'b1; dmem_bus.hsize = 3'b000;
    cyc();
    dmem_bus.htrans = 2'b00; dmem_bus.hwdata = 32'h11000000;
    @(negedge clk);
    chk("wb_en", 32'(ram_en), 32'h1);
    chk("wb_wben", 32'(ram_wben), 32'h8);
    chk("wb_rwn", 32'(ram_rwn), 32'h0);
    chk("wb_write", ram_write, 32'h11000000);
    chk("wb_addr", 32'(ram_addr), 32'h20);
    chk("wb_hready", 32'(dmem_bus.hready), 32'h0);
    cyc();
    dmem_bus.haddr = 32'h22; dmem_bus.htrans = 2'b10; dmem_bus.hwrite = 1'b1; dmem_bus.hsize = 3'b001;
    @(negedge clk);
    chk("wb_done_hready", 32'(dmem_bus.hready), 32'h1);
    chk("wb_done_hrdata", dmem_bus.hrdata, 32'h0);
    cyc();
    dmem_bus.htrans = 2'b00; dmem_bus.hwdata = 32'h22330000;
    @(negedge clk);
    chk("wh_en", 32'(ram_en), 32'h1);
    chk("wh_wben", 32'(ram_wben), 32'hC);
    chk("wh_write", ram_write, 32'h22330000);
    chk("wh_addr", 32'(ram_addr), 32'h20);
    cyc();
    @(negedge clk);
    chk("wh_done_hready", 32'(dmem_bus.hready), 32'h1);

    // Three contested rounds: imem, dmem, imem wins
    do_round(0);
    do_round(1);
    do_round(0);

    // dmem back-to-back reads, imem idle
    cyc();
    dmem_bus.haddr = 32'h100; dmem_bus.htrans = 2'b10; dmem_bus.hwrite = 1'b0; dmem_bus.hsize = 3'b010;
    cyc();
    dmem_bus.haddr = 32'h104;
    @(negedge clk);
    chk("b2b_g0_addr", 32'(ram_addr), 32'h100);
    chk("b2b_g0_hready", 32'(dmem_bus.hready), 32'h0);
    cyc();
    @(negedge clk);
    chk("b2b_d0_hready", 32'(dmem_bus.hready), 32'h1);
    chk("b2b_d0_en", 32'(ram_en), 32'h0);
    cyc();
    dmem_bus.haddr = 32'h108;
    @(negedge clk);
    chk("b2b_g1_addr", 32'(ram_addr), 32'h104);
    chk("b2b_g1_hready", 32'(dmem_bus.hready), 32'h0);
    cyc();
    @(negedge clk);
    chk("b2b_d1_hready", 32'(dmem_bus.hready), 32'h1);
    cyc();
    dmem_bus.htrans = 2'b00;
    @(negedge clk);
    chk("b2b_g2_addr", 32'(ram_addr), 32'h108);
    chk("b2b_g2_hready", 32'(dmem_bus.hready), 32'h0);
    cyc();
    @(negedge clk);
    chk("b2b_d2_hready", 32'(dmem_bus.hready), 32'h1);
    chk("b2b_d2_hrdata", dmem_bus.hrdata, 32'hDEADBEEF);

    // Favour still points at dmem after the uncontested reads
    do_round(1);

    // Reset during a dmem write's grant cycle
    cyc();
    dmem_bus.haddr = 32'h30; dmem_bus.htrans = 2'b10; dmem_bus.hwrite = 1'b1; dmem_bus.hsize = 3'b010;
    cyc();
    dmem_bus.htrans = 2'b00; dmem_bus.hwdata = 32'hCAFE0000;
    #1;
    chk("rstw_pre_en", 32'(ram_en), 32'h1);
    reset = 1'b1;
    #1;
    chk("rstw_en", 32'(ram_en), 32'h0);
    chk("rstw_wben", 32'(ram_wben), 32'h0);
    chk("rstw_dhready", 32'(dmem_bus.hready), 32'h1);
    chk("rstw_ihready", 32'(imem_bus.hready), 32'h1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_after_en", 32'(ram_en), 32'h0);
    chk("rstw_after_dhready", 32'(dmem_bus.hready), 32'h1);
    cyc();
    dmem_bus.haddr = 32'h44; dmem_bus.htrans = 2'b10; dmem_bus.hwrite = 1'b0;
    cyc();
    dmem_bus.htrans = 2'b00;
    @(negedge clk);
    chk("rstw_nx_en", 32'(ram_en), 32'h1);
    chk("rstw_nx_addr", 32'(ram_addr), 32'h44);
    chk("rstw_nx_rwn", 32'(ram_rwn), 32'h1);
    cyc();
    @(negedge clk);
    chk("rstw_nx_hready", 32'(dmem_bus.hready), 32'h1);
    chk("rstw_nx_hrdata", dmem_bus.hrdata, 32'hDEADBEEF);

    // imem read of 0x0001_0000: out of range when error checking is built in
    cyc();
    imem_bus.haddr = 32'h0001_0000; imem_bus.htrans = 2'b10; imem_bus.hwrite = 1'b0; imem_bus.hsize = 3'b010;
    cyc();
    imem_bus.htrans = 2'b00;
    @(negedge clk);
`ifdef MEM_ARB_ERR_EN
    chk("err1_hresp", 32'(imem_bus.hresp), 32'h1);
    chk("err1_hready", 32'(imem_bus.hready), 32'h0);
    chk("err1_en", 32'(ram_en), 32'h0);
    cyc();
    @(negedge clk);
    chk("err2_hresp", 32'(imem_bus.hresp), 32'h1);
    chk("err2_hready", 32'(imem_bus.hready), 32'h1);
    chk("err2_en", 32'(ram_en), 32'h0);
    cyc();
    @(negedge clk);
    chk("err_idle_hresp", 32'(imem_bus.hresp), 32'h0);
    chk("err_idle_en", 32'(ram_en), 32'h0);
`else
    chk("alias_en", 32'(ram_en), 32'h1);
    chk("alias_addr", 32'(ram_addr), 32'h0);
    chk("alias_hresp", 32'(imem_bus.hresp), 32'h0);
    cyc();
    @(negedge clk);
    chk("alias_hready", 32'(imem_bus.hready), 32'h1);
    chk("alias_hrdata", imem_bus.hrdata, 32'hDEADBEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
